// File: rtl/yannickreiss_muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
//   state_t   : FSM states IDLE, CALC, DONE
//   OP_MUL/OP_DIV : op_code encodings
//   cnt_bits  : iteration counter width for a given operand width
package yannickreiss_muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Counter must reach WIDTH itself without wrapping.
  function automatic int unsigned cnt_bits(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/yannickreiss_muldiv_step.sv
// One iteration of the shift-add multiplier or restoring divider.
// Purely combinational.
//   op_i   : OP_MUL / OP_DIV (present only when MULDIV_DIV_EN is defined)
//   opnd_i : multiplicand (multiply) or divisor (divide)
//   hi_i/lo_i : working pair; multiply {partial product, multiplier},
//               divide {partial remainder, dividend/quotient}
//   hi_o/lo_o : working pair after this iteration
// Macro MULDIV_DIV_EN compiles in the subtract path.
module yannickreiss_muldiv_step
  import yannickreiss_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
`ifdef MULDIV_DIV_EN
  input  logic             op_i,
`endif
  input  logic [WIDTH-1:0] opnd_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0] sum;
`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]   sh;
  logic             ge;
`endif

  always_comb begin
    // Add multiplicand when the current multiplier LSB is set, then shift
    // the whole {carry, hi, lo} right by one.
    sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
    hi_o = sum[WIDTH:1];
    lo_o = {sum[0], lo_i[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    sh = {hi_i, lo_i[WIDTH-1]};
    ge = (sh >= {1'b0, opnd_i});
    if (op_i == OP_DIV) begin
      // When sh >= divisor the true difference is below 2**WIDTH, so the
      // low WIDTH bits of the subtraction are exact.
      hi_o = ge ? (sh[WIDTH-1:0] - opnd_i) : sh[WIDTH-1:0];
      lo_o = {lo_i[WIDTH-2:0], ge};
    end
`endif
  end

endmodule

// File: rtl/yannickreiss_muldiv_seq.sv
// Sequential unsigned multiply / divide, one iteration per clock.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start, op_code  : request (sampled in IDLE), 0 = multiply, 1 = divide
//   op_a, op_b      : operands (WIDTH bits)
//   busy, done      : not-IDLE flag, one-cycle result-valid pulse
//   result_hi/lo    : product halves, or remainder/quotient
//   err             : divide by zero, or divide while compiled out
// Macro MULDIV_DIV_EN compiles in the divide datapath.
module yannickreiss_muldiv_seq
  import yannickreiss_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_code,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             err
);

  localparam int unsigned CW = cnt_bits(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] step_hi, step_lo;
`ifdef MULDIV_DIV_EN
  logic             op_q, op_d;
`endif

  yannickreiss_muldiv_step #(.WIDTH(WIDTH)) u_step (
`ifdef MULDIV_DIV_EN
    .op_i   (op_q),
`endif
    .opnd_i (opnd_q),
    .hi_i   (hi_q),
    .lo_i   (lo_q),
    .hi_o   (step_hi),
    .lo_o   (step_lo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      err_q    <= 1'b0;
`ifdef MULDIV_DIV_EN
      op_q     <= OP_MUL;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      err_q    <= err_d;
`ifdef MULDIV_DIV_EN
      op_q     <= op_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    err_d    = err_q;
`ifdef MULDIV_DIV_EN
    op_d     = op_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Multiply walks the multiplier through lo and adds op_a;
          // divide walks the dividend through lo and subtracts op_b.
          state_d = CALC;
          cnt_d   = '0;
          hi_d    = '0;
          opnd_d  = op_a;
          lo_d    = op_b;
`ifdef MULDIV_DIV_EN
          op_d    = op_code;
          if (op_code == OP_DIV) begin
            opnd_d = op_b;
            lo_d   = op_a;
            if (op_b == '0) begin
              state_d  = DONE;
              res_hi_d = op_a;
              res_lo_d = '1;
              err_d    = 1'b1;
            end
          end
`else
          if (op_code == OP_DIV) begin
            state_d  = DONE;
            res_hi_d = '0;
            res_lo_d = '0;
            err_d    = 1'b1;
          end
`endif
        end
      end
      CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = DONE;
          res_hi_d = step_hi;
          res_lo_d = step_lo;
          err_d    = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign result_hi = res_hi_q;
  assign result_lo = res_lo_q;
  assign err       = err_q;

endmodule

// File: tb/tb_yannickreiss_muldiv_seq.sv
// Bench for yannickreiss_muldiv_seq (WIDTH=4). A cycle-level behavioural
// model computes results with plain arithmetic; directed cases pin it.
module tb_yannickreiss_muldiv_seq;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         op_code = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         busy, done, err;
  logic [W-1:0] result_hi, result_lo;

  int vectors = 0;
  int miscompares = 0;

  yannickreiss_muldiv_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_code   (op_code),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .result_hi (result_hi),
    .result_lo (result_lo),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  // m_t: cycles since acceptance (0 = idle); m_L: cycle in which done shows.
  int           m_t = 0;
  int           m_L = 0;
  bit           m_valid = 0;
  logic [W-1:0] p_hi, p_lo, e_hi, e_lo;
  logic         p_err, e_err;

  always begin
    @(posedge clk);
    if (rst) begin
      m_t = 0; m_valid = 1;
      e_hi = '0; e_lo = '0; e_err = 1'b0;
    end else if (m_t == 0) begin
      if (start) begin
        int unsigned ia, ib, pr;
        ia = op_a; ib = op_b;
        if (op_code == 1'b0) begin
          pr = ia * ib;
          p_hi = W'(pr >> W); p_lo = W'(pr); p_err = 1'b0; m_L = W + 1;
        end else begin
`ifdef MULDIV_DIV_EN
          if (ib == 0) begin
            p_hi = op_a; p_lo = '1; p_err = 1'b1; m_L = 1;
          end else begin
            p_hi = W'(ia % ib); p_lo = W'(ia / ib); p_err = 1'b0; m_L = W + 1;
          end
`else
          p_hi = '0; p_lo = '0; p_err = 1'b1; m_L = 1;
`endif
        end
        m_t = 1;
      end
    end else if (m_t == m_L) begin
      m_t = 0;
    end else begin
      m_t++;
    end
    if (m_t != 0 && m_t == m_L) begin
      e_hi = p_hi; e_lo = p_lo; e_err = p_err;
    end
    #1;
    if (m_valid) begin
      check("busy", busy, (m_t != 0));
      check("done", done, (m_t != 0 && m_t == m_L));
      if (m_t == 0 || m_t == m_L) begin
        check("result_hi", result_hi, e_hi);
        check("result_lo", result_lo, e_lo);
        check("err", err, e_err);
      end
    end
  end

  // ---------------- directed helpers ----------------
  // Issues one request from IDLE and waits (bounded) for done; optionally
  // pulses a second request (2 x 2) in the second CALC cycle.
  task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit inject, output int lat, output logic [W-1:0] hi,
                        output logic [W-1:0] lo, output logic e);
    @(negedge clk);
    start = 1'b1; op_code = op; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; hi = 'x; lo = 'x; e = 1'bx;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      if (done) begin
        lat = k; hi = result_hi; lo = result_lo; e = err;
      end else if (inject && k == 2) begin
        @(negedge clk);
        start = 1'b1; op_code = 1'b0; op_a = 4'd2; op_b = 4'd2;
        @(posedge clk); #1;
        start = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
  endtask

  int           lat;
  logic [W-1:0] hi, lo;
  logic         e;

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", result_hi, 0);
    check("rst_lo", result_lo, 0);
    check("rst_err", err, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    run_op(1'b0, 4'd13, 4'd11, 0, lat, hi, lo, e);
    check("mul13x11_lat", lat, 5);
    check("mul13x11_hi", hi, 4'h8);
    check("mul13x11_lo", lo, 4'hF);
    check("mul13x11_err", e, 0);

    run_op(1'b0, 4'd0, 4'd9, 0, lat, hi, lo, e);
    check("mul0x9_lat", lat, 5);
    check("mul0x9_lo", lo, 0);

`ifdef MULDIV_DIV_EN
    run_op(1'b1, 4'd13, 4'd3, 0, lat, hi, lo, e);
    check("div13_3_lo", lo, 4);
    check("div13_3_hi", hi, 1);
    check("div13_3_err", e, 0);
    run_op(1'b1, 4'd3, 4'd7, 0, lat, hi, lo, e);
    check("div3_7_lo", lo, 0);
    check("div3_7_hi", hi, 3);
    run_op(1'b1, 4'd9, 4'd0, 0, lat, hi, lo, e);
    check("div9_0_lat", lat, 1);
    check("div9_0_lo", lo, 4'hF);
    check("div9_0_hi", hi, 9);
    check("div9_0_err", e, 1);
`else
    run_op(1'b1, 4'd8, 4'd2, 0, lat, hi, lo, e);
    check("nodiv_lat", lat, 1);
    check("nodiv_err", e, 1);
    check("nodiv_hi", hi, 0);
    check("nodiv_lo", lo, 0);
    run_op(1'b0, 4'd7, 4'd7, 0, lat, hi, lo, e);
    check("mul7x7_hi", hi, 3);
    check("mul7x7_lo", lo, 1);
`endif

    // Start pulse during CALC is ignored
    run_op(1'b0, 4'd6, 4'd5, 1, lat, hi, lo, e);
    check("ign_lat", lat, 5);
    check("ign_hi", hi, 1);
    check("ign_lo", lo, 4'hE);

    // Reset during the second CALC cycle aborts without done
    @(negedge clk); start = 1'b1; op_code = 1'b0; op_a = 4'd15; op_b = 4'd15;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", busy, 0);
    check("abort_hi", result_hi, 0);
    check("abort_lo", result_lo, 0);
    check("abort_err", err, 0);
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      check("abort_nodone", done, 0);
    end
    run_op(1'b0, 4'd15, 4'd15, 0, lat, hi, lo, e);
    check("mul15x15_hi", hi, 4'hE);
    check("mul15x15_lo", lo, 4'h1);

    // start held high: back-to-back with operands changing every cycle
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      start = 1'b1;
      op_code = 1'($urandom_range(0, 1));
      op_a = W'($urandom);
      op_b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
    end

    // Fully random traffic with occasional resets
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 59) == 0);
      start = ($urandom_range(0, 2) != 0);
      op_code = 1'($urandom_range(0, 1));
      op_a = W'($urandom);
      op_b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
    end
    @(negedge clk); rst = 1'b0; start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/yannickreiss_muldiv_seq.md
YANNICKREISS_MULDIV_SEQ -- requirements
Module: yannickreiss_muldiv_seq

Interface
REQ-001 Parameter WIDTH, default 4: operand width in bits; legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  operation request; sampled only in IDLE.
REQ-005 op_code  input  1  operation select: 0 = multiply, 1 = divide.
REQ-006 op_a  input  WIDTH  unsigned multiplicand or dividend.
REQ-007 op_b  input  WIDTH  unsigned multiplier or divisor.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 done  output  1  one-cycle pulse marking the result as valid.
REQ-010 result_hi  output  WIDTH  multiply: product[2*WIDTH-1:WIDTH]; divide: remainder.
REQ-011 result_lo  output  WIDTH  multiply: product[WIDTH-1:0]; divide: quotient.
REQ-012 err  output  1  divide by zero, or divide requested while divide is compiled out; valid with done.

Function
REQ-013 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-014 IDLE with start=1: on that edge, latch op_code, op_a and op_b, clear the iteration counter, and go to CALC.
REQ-015 CALC SHALL perform one iteration per cycle for exactly WIDTH cycles, then go to DONE.
- Multiply: shift-add.
- Divide: restoring shift-subtract.
REQ-016 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
- Latency: done is high in cycle WIDTH+1 after the accepting edge.
REQ-017 start SHALL be ignored in CALC and DONE, and the latched operands SHALL not change until the next accepted start.
REQ-018 result_hi, result_lo and err SHALL be registered, and SHALL hold their values from the done cycle until the next accepted start.
REQ-019 Arithmetic is unsigned.
- Multiply: full 2*WIDTH-bit product, no truncation.
- Divide: op_a = quotient*op_b + remainder, with remainder < op_b.
REQ-020 Divide with op_b=0: go directly from the accepting edge to DONE (latency 1).
- result_lo = all ones, result_hi = op_a, err=1.
REQ-021 An operand of 0 in multiply SHALL still take the full WIDTH iterations and give a zero product, err=0.
REQ-022 The iteration counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL not wrap within one operation.
REQ-023 start held high continuously SHALL begin a new operation on the first IDLE cycle after each DONE, i.e. back-to-back every WIDTH+2 cycles.

Reset
REQ-024 When rst=1 at an edge:
- state = IDLE, counter = 0;
- busy = 0, done = 0, err = 0;
- result_hi = 0, result_lo = 0.
REQ-025 rst SHALL take priority over start and over any state transition, including an operation in progress in CALC or DONE.
- An aborted operation SHALL produce no done pulse.

Configuration
REQ-026 Macro MULDIV_DIV_EN, when defined, SHALL compile in the divide datapath and REQ-019/REQ-020 divide behaviour.
REQ-027 Without MULDIV_DIV_EN:
- op_code=1 SHALL go directly to DONE (latency 1) with result_hi = 0, result_lo = 0, err=1.
- No subtractor logic SHALL be synthesised.
- Multiply behaviour SHALL be unchanged.

Structure
REQ-028 Shared package yannickreiss_muldiv_pkg SHALL hold:
- the state enum typedef (IDLE, CALC, DONE);
- the opcode constants OP_MUL = 1'b0, OP_DIV = 1'b1.
REQ-029 One combinational sub-module, yannickreiss_muldiv_step, SHALL compute a single shift-add or shift-subtract iteration.
- The top level holds the FSM, counter and registers.

Verification (WIDTH=4, MULDIV_DIV_EN defined unless stated)
REQ-030 Multiply 13 x 11:
- Response: done in cycle 5 after accept; result_hi=0x8, result_lo=0xF, err=0.
REQ-031 Divide 13 / 3:
- Response: result_lo=4, result_hi=1, err=0.
- Also 3 / 7: result_lo=0, result_hi=3.
REQ-032 Divide 9 / 0:
- Response: done the cycle after accept; result_lo=0xF, result_hi=9, err=1.
REQ-033 Start 6 x 5, then pulse start with op_a=2, op_b=2 during CALC:
- Response: result 0x1E (hi=1, lo=0xE); second request ignored.
REQ-034 Assert rst in the 2nd CALC cycle of 15 x 15:
- Response: next cycle busy=0 and outputs are 0; no done pulse.
- A following 15 x 15 gives hi=0xE, lo=0x1.
REQ-035 Build without MULDIV_DIV_EN, divide 8 / 2:
- Response: done at latency 1, err=1, results 0.
- Multiply 7 x 7 gives hi=3, lo=1.
